// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO rempty/rinc read port into a valid/ready
// stream through a two-entry head/skid buffer.
module fifo_rd_stream #(
   parameter int DSIZE   = 8,
   parameter int CNTSIZE = 16
) (
   input  logic               rclk,
   input  logic               rrst_n,
   input  logic [DSIZE-1:0]   rdata,
   input  logic               rempty,
   output logic               rinc,
   output logic [DSIZE-1:0]   dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic [1:0]         level,
   output logic [CNTSIZE-1:0] xfer_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [DSIZE-1:0]   head_q, head_d;
   logic [DSIZE-1:0]   skid_q, skid_d;
   logic               valid_q;
   logic [CNTSIZE-1:0] cnt_q;
   logic               push, pop;

   // state register and datapath registers
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         valid_q <= (state_d != EMPTY);
         if (pop)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // next state and buffer contents from push/pop
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               head_d  = rdata;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && !pop) begin
               skid_d  = rdata;
               state_d = TWO;
            end else if (push && pop) begin
               head_d  = rdata;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               head_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // read request never looks at dout_ready, so no ready->rinc path exists
   always_comb begin
      rinc       = rrst_n & ~rempty & (state_q != TWO);
      push       = rinc;
      pop        = valid_q & dout_ready;
      dout       = head_q;
      dout_valid = valid_q;
      level      = state_q;
      xfer_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of the read-side stream buffer.
// Inputs change 1ns after rclk rises; outputs are checked after that.
module tb_fifo_rd_stream;

   logic        rclk;
   logic        rrst_n;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic [1:0]  level;
   logic [15:0] xfer_cnt;

   int total;
   int bad;

   fifo_rd_stream #(.DSIZE(8), .CNTSIZE(16)) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rdata      (rdata),
      .rempty     (rempty),
      .rinc       (rinc),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level),
      .xfer_cnt   (xfer_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   initial begin
      int errs;
      int n;
      logic [7:0] prev;
      total = 0;
      bad   = 0;

      // reset state, rinc gated by reset even with rempty low
      rrst_n     = 1'b0;
      rempty     = 1'b1;
      rdata      = 8'h00;
      dout_ready = 1'b0;
      tick();
      tick();
      rempty = 1'b0;
      #1;
      chk("rst_rinc", {31'd0, rinc}, 32'd0);
      chk("rst_level", {30'd0, level}, 32'd0);
      chk("rst_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);

      // streaming 11,22,33 with ready high
      rrst_n     = 1'b1;
      rdata      = 8'h11;
      dout_ready = 1'b1;
      #1;
      chk("s_rinc0", {31'd0, rinc}, 32'd1);
      tick();
      chk("s_valid1", {31'd0, dout_valid}, 32'd1);
      chk("s_dout11", {24'd0, dout}, 32'h11);
      rdata = 8'h22;
      tick();
      chk("s_dout22", {24'd0, dout}, 32'h22);
      chk("s_cnt1", {16'd0, xfer_cnt}, 32'd1);
      rdata = 8'h33;
      tick();
      chk("s_dout33", {24'd0, dout}, 32'h33);
      rempty = 1'b1;
      tick();
      chk("s_cnt3", {16'd0, xfer_cnt}, 32'd3);
      chk("s_valid0", {31'd0, dout_valid}, 32'd0);
      chk("s_hold", {24'd0, dout}, 32'h33);

      // backpressure: fill to two, rinc drops, then drain in order
      dout_ready = 1'b0;
      rempty     = 1'b0;
      rdata      = 8'hA1;
      tick();
      chk("bp_lvl1", {30'd0, level}, 32'd1);
      rdata = 8'hA2;
      #1;
      chk("bp_rinc1", {31'd0, rinc}, 32'd1);
      tick();
      chk("bp_lvl2", {30'd0, level}, 32'd2);
      chk("bp_rinc0", {31'd0, rinc}, 32'd0);
      tick();
      chk("bp_stable", {24'd0, dout}, 32'hA1);
      chk("bp_lvl2b", {30'd0, level}, 32'd2);
      dout_ready = 1'b1;
      rempty     = 1'b1;
      tick();
      chk("bp_doutA2", {24'd0, dout}, 32'hA2);
      chk("bp_lvl1b", {30'd0, level}, 32'd1);
      chk("bp_cnt4", {16'd0, xfer_cnt}, 32'd4);
      tick();
      chk("bp_lvl0", {30'd0, level}, 32'd0);
      chk("bp_cnt5", {16'd0, xfer_cnt}, 32'd5);

      // simultaneous push and pop at level one
      dout_ready = 1'b0;
      rempty     = 1'b0;
      rdata      = 8'h55;
      tick();
      chk("pp_dout55", {24'd0, dout}, 32'h55);
      rdata      = 8'h66;
      dout_ready = 1'b1;
      tick();
      chk("pp_dout66", {24'd0, dout}, 32'h66);
      chk("pp_lvl1", {30'd0, level}, 32'd1);
      chk("pp_cnt6", {16'd0, xfer_cnt}, 32'd6);
      rempty = 1'b1;
      tick();
      chk("pp_cnt7", {16'd0, xfer_cnt}, 32'd7);

      // rempty rises at level two; buffer still drains
      dout_ready = 1'b0;
      rempty     = 1'b0;
      rdata      = 8'hB1;
      tick();
      rdata = 8'hB2;
      tick();
      rempty     = 1'b1;
      dout_ready = 1'b1;
      #1;
      chk("re_rinc", {31'd0, rinc}, 32'd0);
      chk("re_doutB1", {24'd0, dout}, 32'hB1);
      tick();
      chk("re_doutB2", {24'd0, dout}, 32'hB2);
      chk("re_cnt8", {16'd0, xfer_cnt}, 32'd8);
      tick();
      chk("re_valid0", {31'd0, dout_valid}, 32'd0);
      chk("re_cnt9", {16'd0, xfer_cnt}, 32'd9);

      // asynchronous reset mid-cycle with two words held
      dout_ready = 1'b0;
      rempty     = 1'b0;
      rdata      = 8'hC1;
      tick();
      rdata = 8'hC2;
      tick();
      chk("ar_lvl2", {30'd0, level}, 32'd2);
      #2;
      rrst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, dout_valid}, 32'd0);
      chk("ar_level", {30'd0, level}, 32'd0);
      chk("ar_cnt", {16'd0, xfer_cnt}, 32'd0);
      chk("ar_rinc", {31'd0, rinc}, 32'd0);
      tick();
      rrst_n     = 1'b1;
      rempty     = 1'b1;
      dout_ready = 1'b1;
      tick();
      chk("ar_nostale", {31'd0, dout_valid}, 32'd0);
      chk("ar_dout0", {24'd0, dout}, 32'd0);

      // long stream up to counter wrap, checking order each cycle
      rempty = 1'b0;
      rdata  = 8'h00;
      prev   = 8'h00;
      errs   = 0;
      n      = 0;
      tick();
      while (xfer_cnt != 16'hFFFF && n < 70000) begin
         if (dout !== prev || dout_valid !== 1'b1)
            errs++;
         prev  = prev + 8'd1;
         rdata = prev;
         tick();
         n++;
      end
      chk("wr_order", errs, 32'd0);
      chk("wr_cntmax", {16'd0, xfer_cnt}, 32'hFFFF);
      rempty = 1'b1;
      tick();
      chk("wr_cnt0", {16'd0, xfer_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
